// File: rtl/rx_frame_fsm.sv
// rx_frame_fsm: oversampled UART receive controller.
//   Detects a start edge, confirms it at mid start bit, then samples DATA_BITS data bits
//   (LSB first), an optional parity bit and STOP_BITS stop bits once per bit period.
//   The received word and its error flags are presented with a valid/ready handshake.
//   All decisions are taken on cycles with sample_tick=1; other cycles hold state.
// Ports:
//   fsm_clk     clock, all logic on posedge
//   fsm_rst     synchronous active-high reset
//   sample_tick one-cycle strobe, OVERSAMPLE per bit period
//   rxd         synchronised serial input, idle high
//   rx_ready    consumer accepts rx_data when rx_valid && rx_ready
//   rx_data     received word
//   rx_valid    rx_data holds an unconsumed word
//   parity_err  parity mismatch on the word in rx_data
//   frame_err   a checked stop bit sampled 0 on the word in rx_data
//   overrun     one-cycle pulse: new word overwrote an unconsumed one
//   load        one-cycle pulse when rx_data and flags update
//   shift       one-cycle pulse per data bit sampled
//   busy        registered, high while the receiver is not idle
module rx_frame_fsm #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 fsm_clk,
  input  logic                 fsm_rst,
  input  logic                 sample_tick,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 load,
  output logic                 shift,
  output logic                 busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickEnd  = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  LastData = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  LastStop = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StLoad} state_e;

  state_e               state_q, state_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bad_q, par_bad_d;
  logic                 stop_bad_q, stop_bad_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 load_q, load_d;
  logic                 busy_q, busy_d;

  logic tick_end;
  logic load_fire;
  logic accept;

  assign tick_end = sample_tick && (tick_cnt_q == TickEnd);

  // State and datapath registers
  always_ff @(posedge fsm_clk) begin
    if (fsm_rst) begin
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_bad_q    <= par_bad_d;
      stop_bad_q   <= stop_bad_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;

    if (sample_tick && state_q != StIdle && state_q != StLoad) begin
      tick_cnt_d = tick_end ? '0 : tick_cnt_q + TickW'(1);
    end

    case (state_q)
      StIdle: begin
        if (sample_tick && !rxd) begin
          state_d    = StStart;
          tick_cnt_d = '0;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
        end
      end
      StStart: begin
        if (sample_tick && tick_cnt_q == TickMid) begin
          tick_cnt_d = '0;
          if (rxd) begin
            state_d = StIdle;  // start bit did not hold to mid-bit: glitch
          end else begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
      end
      StData: begin
        if (tick_end) begin
          shreg_d = {rxd, shreg_q[DATA_BITS-1:1]};  // LSB arrives first, ends at bit 0
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = '0;  // reused to count stop bits
            state_d   = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (tick_end) begin
          par_bad_d = (^{shreg_q, rxd}) ^ (PARITY_ODD != 0);
          state_d   = StStop;
        end
      end
      StStop: begin
        if (tick_end) begin
          if (!rxd) stop_bad_d = 1'b1;
          // Leaving at mid-stop lets the next start edge be caught right after the stop bit
          if (bit_cnt_q == LastStop) begin
            state_d = StLoad;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StLoad: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic
  always_comb begin
    load_fire = (state_q == StLoad);
    accept    = rx_valid_q && rx_ready;
    shift     = (state_q == StData) && tick_end;

    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = rx_valid_q;
    if (load_fire) begin
      rx_data_d    = shreg_q;
      parity_err_d = (PARITY_EN != 0) && par_bad_q;
      frame_err_d  = stop_bad_q;
      rx_valid_d   = 1'b1;  // a load wins over a same-cycle accept
    end else if (accept) begin
      rx_valid_d = 1'b0;
    end
    overrun_d = load_fire && rx_valid_q && !rx_ready;
    load_d    = load_fire;
    busy_d    = (state_q != StIdle);
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign load       = load_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rx_frame_fsm.sv
// Directed bench for rx_frame_fsm (8 data bits, 16x oversample, even parity, 1 stop bit).
// Expected words are queued when a frame is driven and compared when load pulses.
module tb_rx_frame_fsm;

  logic       fsm_clk = 1'b0;
  logic       fsm_rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, load, shift, busy;

  int compared = 0;
  int mismatched = 0;
  int shift_cnt = 0;
  int load_cnt = 0;
  int ovr_cnt = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t sb[$];

  rx_frame_fsm #(
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .PARITY_EN (1),
    .PARITY_ODD(0),
    .STOP_BITS (1)
  ) dut (
    .fsm_clk    (fsm_clk),
    .fsm_rst    (fsm_rst),
    .sample_tick(sample_tick),
    .rxd        (rxd),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .load       (load),
    .shift      (shift),
    .busy       (busy)
  );

  always #5 fsm_clk = ~fsm_clk;

  // sample_tick every third clock, updated just after the rising edge
  initial begin : tick_gen
    int cnt;
    cnt = 0;
    forever begin
      @(posedge fsm_clk);
      #1;
      sample_tick = (cnt == 2);
      cnt = (cnt == 2) ? 0 : cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: event counters and scoreboard pop on each load
  always @(negedge fsm_clk) begin : monitor
    exp_t e;
    if (shift === 1'b1) shift_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (load === 1'b1) begin
      load_cnt++;
      check("load has queued word", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.d));
        check("parity_err", 32'(parity_err), 32'(e.pe));
        check("frame_err", 32'(frame_err), 32'(e.fe));
        check("rx_valid at load", 32'(rx_valid), 32'd1);
      end
    end
  end

  // Returns #1 after the rising edge that consumed the n-th tick
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge fsm_clk);
      while (sample_tick !== 1'b1) @(posedge fsm_clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    wait_ticks(16);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pbit, input logic sbit);
    exp_t e;
    e.d  = d;
    e.pe = pbit ^ (^d);
    e.fe = ~sbit;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                            input int gap);
    push_exp(d, pbit, sbit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pbit);
    send_bit(sbit);
    rxd = 1'b1;
    wait_ticks(gap);
  endtask

  initial begin : stim
    int sh0, ld0, ov0, waited;
    logic [7:0] w;

    // Reset state
    fsm_rst = 1'b1;
    repeat (3) @(posedge fsm_clk);
    @(negedge fsm_clk);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset parity_err", 32'(parity_err), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset load", 32'(load), 32'd0);
    @(posedge fsm_clk);
    #1 fsm_rst = 1'b0;
    wait_ticks(8);

    // 1: clean frame 0xA5 with latency and shift-count checks
    w = 8'hA5;
    sh0 = shift_cnt;
    push_exp(w, 1'b0, 1'b1);
    send_bit(1'b0);
    @(negedge fsm_clk);
    check("t1 busy mid-frame", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    send_bit(1'b0);
    rxd = 1'b1;
    wait_ticks(9);  // returns on the stop-sample edge
    @(negedge fsm_clk);
    check("t1 rx_valid 1 clk after stop", 32'(rx_valid), 32'd0);
    @(negedge fsm_clk);
    check("t1 rx_valid 2 clk after stop", 32'(rx_valid), 32'd1);
    check("t1 load pulse", 32'(load), 32'd1);
    @(negedge fsm_clk);
    check("t1 rx_valid cleared by accept", 32'(rx_valid), 32'd0);
    check("t1 load one cycle", 32'(load), 32'd0);
    check("t1 shift pulses", 32'(shift_cnt - sh0), 32'd8);
    wait_ticks(7 + 16);
    @(negedge fsm_clk);
    check("t1 busy after frame", 32'(busy), 32'd0);

    // 2: start glitch
    sh0 = shift_cnt;
    ld0 = load_cnt;
    @(posedge fsm_clk);
    #1 rxd = 1'b0;
    wait_ticks(2);
    @(negedge fsm_clk);
    check("t2 busy during start", 32'(busy), 32'd1);
    wait_ticks(2);
    rxd = 1'b1;
    wait_ticks(20);
    @(negedge fsm_clk);
    check("t2 busy after abort", 32'(busy), 32'd0);
    check("t2 no shift", 32'(shift_cnt - sh0), 32'd0);
    check("t2 no load", 32'(load_cnt - ld0), 32'd0);
    check("t2 no rx_valid", 32'(rx_valid), 32'd0);

    // 3: parity error
    @(posedge fsm_clk);
    #1;
    send_frame(8'hA5, 1'b1, 1'b1, 16);

    // 4: framing error, then a clean frame clears it
    send_frame(8'h3C, 1'b0, 1'b0, 32);
    check("t4 frame_err held", 32'(frame_err), 32'd1);
    send_frame(8'h01, 1'b1, 1'b1, 16);
    check("t4 frame_err cleared", 32'(frame_err), 32'd0);

    // 5: overrun with rx_ready low, back-to-back frames
    rx_ready = 1'b0;
    ov0 = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 8);
    @(negedge fsm_clk);
    check("t5 overrun pulses", 32'(ovr_cnt - ov0), 32'd1);
    check("t5 rx_valid held", 32'(rx_valid), 32'd1);
    check("t5 rx_data newest", 32'(rx_data), 32'h22);
    rx_ready = 1'b1;
    waited = 0;
    while (rx_valid === 1'b1 && waited < 5) begin
      @(negedge fsm_clk);
      waited++;
    end
    check("t5 rx_valid cleared after accept", 32'(rx_valid), 32'd0);

    // 6: reset during data bit 3, then a clean frame
    ld0 = load_cnt;
    @(posedge fsm_clk);
    #1;
    w = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(w[i]);
    rxd = w[3];
    wait_ticks(8);
    fsm_rst = 1'b1;
    @(posedge fsm_clk);
    #1 fsm_rst = 1'b0;
    @(negedge fsm_clk);
    check("t6 busy after reset", 32'(busy), 32'd0);
    check("t6 rx_valid after reset", 32'(rx_valid), 32'd0);
    rxd = 1'b1;
    wait_ticks(48);
    check("t6 aborted frame not loaded", 32'(load_cnt - ld0), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 16);

    @(negedge fsm_clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    check("total loads", 32'(load_cnt), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
